// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud-select constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Baud-select encodings understood by the baud rate generator.
  localparam logic [2:0] BAUD_SEL_9600   = 3'd0;
  localparam logic [2:0] BAUD_SEL_19200  = 3'd1;
  localparam logic [2:0] BAUD_SEL_38400  = 3'd2;
  localparam logic [2:0] BAUD_SEL_57600  = 3'd3;
  localparam logic [2:0] BAUD_SEL_115200 = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-byte valid/ready stream with frame status
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, parity_error, framing_error, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_error, framing_error, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for asynchronous single-bit inputs
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity/framing status and
// a held valid/ready output that drops new frames while the previous is unaccepted.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick_i,
  input  logic        rx_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  uart_rx_if.master   rx_o
);

  localparam int TCW = $clog2(OVERSAMPLING);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLING / 2 - 1);
  localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLING - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);

  logic rx_s;

  uart_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_i),
    .q_o (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_en_q, par_odd_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;
  logic                 shift_en, par_sample, commit;
  logic                 perr_now;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // START counts only half a bit so later states sample at mid-bit.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (sample_tick_i) begin
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          if (!rx_s) state_d = START;
        end
        START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? IDLE : BREAK_WAIT;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        BREAK_WAIT: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en   = 1'b0;
    par_sample = 1'b0;
    commit     = 1'b0;
    if (sample_tick_i && tick_cnt_q == TICK_LAST) begin
      shift_en   = (state_q == DATA);
      par_sample = (state_q == PARITY);
      commit     = (state_q == STOP);
    end
  end

  assign perr_now = par_en_q & ((^shift_q ^ par_bit_q) != par_odd_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        par_en_q  <= parity_en_i;
        par_odd_q <= parity_odd_i;
      end
      if (shift_en)   shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (par_sample) par_bit_q <= rx_s;
    end
  end

  // A commit may replace the held frame only if that frame leaves this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (commit) begin
        if (!valid_q || rx_o.rx_ready) begin
          data_q  <= shift_q;
          perr_q  <= perr_now;
          ferr_q  <= ~rx_s;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_o.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_o.rx_data       = data_q;
  assign rx_o.rx_valid      = valid_q;
  assign rx_o.parity_error  = perr_q;
  assign rx_o.framing_error = ferr_q;
  assign rx_o.overrun       = ovr_q;

endmodule
